wb_align_stage: RTL and testbench

Parametrised RV writeback stage that retires ALU results and memory loads into the register-file write port. It accepts one instruction per handshake and waits in a state machine for multi-cycle memory responses. Load data is aligned by byte offset and sign/zero-extended by funct3. Misaligned and illegal load widths are flagged. It sits between the execute/memory stage and the register file.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/ld_extend.sv | 67 ++++++
 rtl/wb_align_stage.sv | 123 ++++++++++++
 tb/tb_wb_align_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV writeback definitions: load funct3 encodings, writeback FSM states,
// and the default datapath width.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

endpackage

// File: rtl/ld_extend.sv
// Combinational load aligner: shifts read data by the byte offset, then sign- or
// zero-extends by funct3 and flags misaligned or unsupported widths.
module ld_extend
    import rv_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  d_out,
    input  logic [OFF_W-1:0] addr_lo,
    input  logic [2:0]       f3,
    output logic [XLEN-1:0]  ld_val,
    output logic             misalign,
    output logic             illegal
);

    logic        [XLEN-1:0] sh;
    logic signed [7:0]      b_s;
    logic signed [15:0]     h_s;
    logic signed [31:0]     w_s;

    assign sh  = d_out >> {addr_lo, 3'b000};
    assign b_s = signed'(sh[7:0]);
    assign h_s = signed'(sh[15:0]);
    assign w_s = signed'(sh[31:0]);

    // Signed size casts perform the sign extension; unsigned casts zero-extend.
    always_comb begin
        ld_val   = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (f3)
            F3_LB:  ld_val = XLEN'(b_s);
            F3_LH: begin
                ld_val   = XLEN'(h_s);
                misalign = addr_lo[0];
            end
            F3_LW: begin
                ld_val   = XLEN'(w_s);
                misalign = |addr_lo[1:0];
            end
            F3_LBU: ld_val = XLEN'(sh[7:0]);
            F3_LHU: begin
                ld_val   = XLEN'(sh[15:0]);
                misalign = addr_lo[0];
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    ld_val   = sh;
                    misalign = |addr_lo;
                end else begin
                    illegal = 1'b1;
                end
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    ld_val   = XLEN'(sh[31:0]);
                    misalign = |addr_lo[1:0];
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_align_stage.sv
// RV writeback stage: retires ALU results and aligned memory loads to the register file.
// Optional macro WB_FWD_EN adds a bypass (rs1/rs2 hit detection) off the registered outputs.
module wb_align_stage
    import rv_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int REG_AW = 5,
    localparam int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_reg_w_en,
    input  logic              ld_en,
    input  logic [2:0]        f3,
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [XLEN-1:0]   d_out,
    input  logic              d_valid,
`ifdef WB_FWD_EN
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd_val,
`endif
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_reg,
    output logic [XLEN-1:0]   wb_val,
    output logic              load_fault
);

    state_t             state_q;
    logic [REG_AW-1:0]  rd_q;
    logic [2:0]         f3_q;
    logic [OFF_W-1:0]   addr_lo_q;
    logic               wb_en_q;
    logic [REG_AW-1:0]  wb_reg_q;
    logic [XLEN-1:0]    wb_val_q;
    logic               load_fault_q;

    logic [XLEN-1:0]    ld_val;
    logic               misalign;
    logic               illegal;
    logic               fault_d;
    logic               ld_wr_d;
    logic               alu_wr_d;

    // The extender sees the captured load attributes; only d_out is live.
    ld_extend #(.XLEN(XLEN)) u_ld_extend (
        .d_out    (d_out),
        .addr_lo  (addr_lo_q),
        .f3       (f3_q),
        .ld_val   (ld_val),
        .misalign (misalign),
        .illegal  (illegal)
    );

    assign fault_d  = misalign | illegal;
    assign ld_wr_d  = !fault_d && (rd_q != '0);
    assign alu_wr_d = alu_reg_w_en && (alu_rd != '0);
    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_q         <= '0;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            wb_en_q      <= 1'b0;
            wb_reg_q     <= '0;
            wb_val_q     <= '0;
            load_fault_q <= 1'b0;
        end else begin
            wb_en_q      <= 1'b0;
            load_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (ld_en) begin
                            state_q   <= WAIT_MEM;
                            rd_q      <= alu_rd;
                            f3_q      <= f3;
                            addr_lo_q <= addr_lo;
                        end else if (alu_wr_d) begin
                            wb_en_q  <= 1'b1;
                            wb_reg_q <= alu_rd;
                            wb_val_q <= alu_result;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (d_valid) begin
                        state_q <= IDLE;
                        if (fault_d) begin
                            load_fault_q <= 1'b1;
                            wb_val_q     <= '0;
                        end else if (ld_wr_d) begin
                            wb_en_q  <= 1'b1;
                            wb_reg_q <= rd_q;
                            wb_val_q <= ld_val;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_reg     = wb_reg_q;
    assign wb_val     = wb_val_q;
    assign load_fault = load_fault_q;

`ifdef WB_FWD_EN
    assign fwd1_hit = wb_en_q && (wb_reg_q == rs1) && (rs1 != '0);
    assign fwd2_hit = wb_en_q && (wb_reg_q == rs2) && (rs2 != '0);
    assign fwd_val  = wb_val_q;
`endif

endmodule

// File: tb/tb_wb_align_stage.sv
// Self-checking bench for wb_align_stage (XLEN=32): directed scenarios plus randomized
// ALU/load traffic compared against an arithmetic load model.
module tb_wb_align_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_result;
    logic              alu_reg_w_en;
    logic              ld_en;
    logic [2:0]        f3;
    logic [1:0]        addr_lo;
    logic [XLEN-1:0]   d_out;
    logic              d_valid;
    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic [XLEN-1:0]   wb_val;
    logic              load_fault;

    int errors = 0;
    int checks = 0;

    logic [REG_AW-1:0] exp_reg;
    logic [XLEN-1:0]   exp_val;

    wb_align_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .alu_reg_w_en (alu_reg_w_en),
        .ld_en        (ld_en),
        .f3           (f3),
        .addr_lo      (addr_lo),
        .d_out        (d_out),
        .d_valid      (d_valid),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .wb_val       (wb_val),
        .load_fault   (load_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result from the ISA rules: take the addressed bytes, then extend to 32 bits.
    function automatic void model_load(input logic [2:0] lf3, input logic [1:0] off,
                                       input logic [31:0] d, output logic [31:0] v,
                                       output bit flt);
        logic [31:0] sh;
        longint      m;
        longint      x;
        int          size;
        bit          sgn;
        sh   = d >> (8 * off);
        flt  = 1'b0;
        v    = '0;
        size = 1;
        sgn  = 1'b0;
        case (lf3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: flt = 1'b1;
        endcase
        if (!flt && (int'(off) % size) != 0) flt = 1'b1;
        if (!flt) begin
            m = longint'(1) << (8 * size);
            x = longint'(sh) % m;
            if (sgn && x >= m / 2) x = x - m;
            v = x[31:0];
        end
    endfunction

    task automatic run_alu(input logic [4:0] rd, input logic [31:0] val, input logic we,
                           input string tag);
        logic exp_en;
        in_valid     = 1'b1;
        ld_en        = 1'b0;
        alu_rd       = rd;
        alu_result   = val;
        alu_reg_w_en = we;
        f3           = 3'($urandom);
        addr_lo      = 2'($urandom);
        tick();
        in_valid = 1'b0;
        exp_en = we && (rd != 0);
        if (exp_en) begin
            exp_reg = rd;
            exp_val = val;
        end
        checks++;
        if (wb_en !== exp_en) begin
            errors++;
            $display("FAIL %s wb_en: got %b want %b", tag, wb_en, exp_en);
        end
        checks++;
        if (wb_reg !== exp_reg || wb_val !== exp_val) begin
            errors++;
            $display("FAIL %s wb_reg/wb_val: got %0d/%h want %0d/%h", tag, wb_reg, wb_val,
                     exp_reg, exp_val);
        end
        checks++;
        if (load_fault !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s fault/ready: got %b/%b want 0/1", tag, load_fault, in_ready);
        end
    endtask

    task automatic run_load(input logic [4:0] rd, input logic [2:0] lf3, input logic [1:0] off,
                            input logic [31:0] d, input int waits, input string tag);
        logic [31:0] mv;
        bit          mf;
        logic        exp_en;
        int          busy;
        model_load(lf3, off, d, mv, mf);
        in_valid     = 1'b1;
        ld_en        = 1'b1;
        alu_rd       = rd;
        f3           = lf3;
        addr_lo      = off;
        alu_result   = $urandom;
        alu_reg_w_en = 1'($urandom);
        d_valid      = 1'b0;
        tick();
        in_valid = 1'b0;
        ld_en    = 1'b0;
        alu_rd   = 5'($urandom);
        f3       = 3'($urandom);
        addr_lo  = 2'($urandom);
        d_out    = $urandom;
        busy     = (in_ready === 1'b0) ? 1 : 0;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (in_ready === 1'b0) busy++;
            checks++;
            if (wb_en !== 1'b0 || load_fault !== 1'b0) begin
                errors++;
                $display("FAIL %s early retire: wb_en=%b load_fault=%b want 0/0", tag, wb_en,
                         load_fault);
            end
        end
        checks++;
        if (busy != waits + 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", tag, busy, waits + 1);
        end
        d_out   = d;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        d_out   = $urandom;
        exp_en  = !mf && (rd != 0);
        if (mf) begin
            exp_val = '0;
        end else if (exp_en) begin
            exp_reg = rd;
            exp_val = mv;
        end
        checks++;
        if (wb_en !== exp_en || load_fault !== mf) begin
            errors++;
            $display("FAIL %s wb_en/load_fault: got %b/%b want %b/%b", tag, wb_en, load_fault,
                     exp_en, mf);
        end
        checks++;
        if (wb_val !== exp_val || wb_reg !== exp_reg) begin
            errors++;
            $display("FAIL %s wb_val/wb_reg: got %h/%0d want %h/%0d", tag, wb_val, wb_reg,
                     exp_val, exp_reg);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready after retire: got %b want 1", tag, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_reg = '0;
        exp_val = '0;
        checks++;
        if (wb_en !== 1'b0 || load_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset strobes: got wb_en=%b load_fault=%b want 0/0", wb_en, load_fault);
        end
        checks++;
        if (wb_reg !== 5'd0 || wb_val !== 32'd0) begin
            errors++;
            $display("FAIL reset data: got %0d/%h want 0/0", wb_reg, wb_val);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_alu();
        run_alu(5'd5, 32'h1234_5678, 1'b1, "alu_rd5");
        run_alu(5'd0, 32'hDEAD_BEEF, 1'b1, "alu_rd0");
        run_alu(5'd9, 32'hCAFE_0001, 1'b0, "alu_nowe");
    endtask

    task automatic test_idle_dvalid();
        d_valid = 1'b1;
        d_out   = 32'hFFFF_FFFF;
        tick();
        d_valid = 1'b0;
        checks++;
        if (wb_en !== 1'b0 || load_fault !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_dvalid: got wb_en=%b fault=%b ready=%b want 0/0/1", wb_en,
                     load_fault, in_ready);
        end
    endtask

    task automatic test_loads();
        run_load(5'd3, 3'b000, 2'd2, 32'h0080_0000, 3, "lb_sign");
        checks++;
        if (wb_val !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sign value: got %h want ffffff80", wb_val);
        end
        run_load(5'd4, 3'b101, 2'd2, 32'hBEEF_0000, 1, "lhu");
        checks++;
        if (wb_val !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL lhu value: got %h want 0000beef", wb_val);
        end
        run_load(5'd6, 3'b001, 2'd2, 32'hBEEF_0000, 0, "lh");
        checks++;
        if (wb_val !== 32'hFFFF_BEEF) begin
            errors++;
            $display("FAIL lh value: got %h want ffffbeef", wb_val);
        end
        run_load(5'd7, 3'b100, 2'd3, 32'h8100_0000, 2, "lbu");
        run_load(5'd8, 3'b010, 2'd0, 32'h8765_4321, 0, "lw");
        run_load(5'd0, 3'b010, 2'd0, 32'h1111_2222, 1, "lw_rd0");
    endtask

    task automatic test_fault();
        run_load(5'd10, 3'b010, 2'd1, 32'h1234_5678, 0, "lw_misalign");
        run_load(5'd11, 3'b111, 2'd0, 32'h1234_5678, 2, "f3_111");
        run_load(5'd12, 3'b011, 2'd0, 32'h1234_5678, 0, "ld_rv32");
        run_load(5'd13, 3'b101, 2'd3, 32'h1234_5678, 1, "lhu_misalign");
        run_load(5'd0, 3'b110, 2'd0, 32'h1234_5678, 0, "lwu_rd0");
    endtask

    task automatic test_reset_midload();
        in_valid = 1'b1;
        ld_en    = 1'b1;
        alu_rd   = 5'd14;
        f3       = 3'b010;
        addr_lo  = 2'd0;
        tick();
        in_valid = 1'b0;
        ld_en    = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_out   = 32'h5555_AAAA;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        exp_reg = '0;
        exp_val = '0;
        checks++;
        if (wb_en !== 1'b0 || load_fault !== 1'b0) begin
            errors++;
            $display("FAIL midload_rst strobes: got %b/%b want 0/0", wb_en, load_fault);
        end
        checks++;
        if (in_ready !== 1'b1 || wb_reg !== 5'd0 || wb_val !== 32'd0) begin
            errors++;
            $display("FAIL midload_rst state: ready=%b reg=%0d val=%h want 1/0/0", in_ready,
                     wb_reg, wb_val);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        ld_en    = 1'b1;
        alu_rd   = 5'd7;
        f3       = 3'b010;
        addr_lo  = 2'd0;
        tick();
        ld_en        = 1'b0;
        alu_rd       = 5'd9;
        alu_result   = 32'h0000_0099;
        alu_reg_w_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (wb_en !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: wb_en=%b ready=%b want 0/0", i, wb_en, in_ready);
            end
        end
        d_out   = 32'h0000_0077;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        checks++;
        if (wb_en !== 1'b1 || wb_reg !== 5'd7 || wb_val !== 32'h77) begin
            errors++;
            $display("FAIL bp_first: got %b/%0d/%h want 1/7/00000077", wb_en, wb_reg, wb_val);
        end
        tick();
        in_valid = 1'b0;
        exp_reg  = 5'd9;
        exp_val  = 32'h99;
        checks++;
        if (wb_en !== 1'b1 || wb_reg !== 5'd9 || wb_val !== 32'h99) begin
            errors++;
            $display("FAIL bp_second: got %b/%0d/%h want 1/9/00000099", wb_en, wb_reg, wb_val);
        end
        run_alu(5'd1, 32'hA5A5_A5A5, 1'b1, "b2b_a");
        run_alu(5'd2, 32'h5A5A_5A5A, 1'b1, "b2b_b");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_alu(5'($urandom), $urandom, 1'($urandom), "rnd_alu");
            end else begin
                run_load(5'($urandom_range(0, 31)), 3'($urandom), 2'($urandom), $urandom,
                         int'($urandom_range(0, 3)), "rnd_load");
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        alu_rd       = '0;
        alu_result   = '0;
        alu_reg_w_en = 1'b0;
        ld_en        = 1'b0;
        f3           = '0;
        addr_lo      = '0;
        d_out        = '0;
        d_valid      = 1'b0;
        exp_reg      = '0;
        exp_val      = '0;
        test_reset();
        test_alu();
        test_idle_dvalid();
        test_loads();
        test_fault();
        test_reset_midload();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
